// File: rtl/arith_pkg.sv
// Shared constants and types for the arithmetic datapath blocks.
package arith_pkg;

   localparam int DIV_W     = 4;
   localparam int DIV_CNT_W = $clog2(DIV_W + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } div_state_t;

endpackage

// File: rtl/subnb.sv
// N-bit ripple subtractor: a - b computed as a + ~b + 1 on full-adder cells.
// Borrow is the inverted final carry, so it is high exactly when a < b.
module subnb #(
   parameter int N = 5
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] Diff,
   output logic         Borrow
);

   logic [N:0] carry_s;

   assign carry_s[0] = 1'b1;

   for (genvar i = 0; i < N; i++) begin : g_bit
      sum1b u_sum1b (
         .a    (a[i]),
         .b    (~b[i]),
         .cin  (carry_s[i]),
         .s    (Diff[i]),
         .cout (carry_s[i+1])
      );
   end

   assign Borrow = ~carry_s[N];

endmodule

// File: rtl/sum1b.sv
// One-bit full adder cell, the building block of the ripple adder/subtractor.
module sum1b (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/div4b.sv
// Sequential unsigned restoring divider, one quotient bit per clock,
// with a start/done handshake. Division by zero skips the iteration and
// reports all-ones quotient, the dividend as remainder and a flag.
module div4b
   import arith_pkg::*;
#(
   parameter int W = DIV_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [W-1:0] A,
   input  logic [W-1:0] B,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] Q,
   output logic [W-1:0] R,
   output logic         div_by_zero
);

   localparam int CW = $clog2(W + 1);

   div_state_t    state_q, state_d;
   logic [W-1:0]  dvd_q, dvd_d;          // dividend shift register
   logic [W-1:0]  dvs_q, dvs_d;          // divisor
   logic [W:0]    pr_q, pr_d;            // partial remainder, one spare bit for 2B-1
   logic [W-1:0]  quo_q, quo_d;          // working quotient
   logic [CW-1:0] cnt_q, cnt_d;
   logic          dbz_pend_q, dbz_pend_d; // zero divisor result still to be published
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [W-1:0]  q_q, q_d;
   logic [W-1:0]  r_q, r_d;
   logic          dbz_q, dbz_d;

   logic [W:0]    pr_shift_s;
   logic [W:0]    diff_s;
   logic          borrow_s;
   logic [W:0]    pr_next_s;
   logic [W-1:0]  quo_next_s;
   logic          last_iter_s;

   assign pr_shift_s  = {pr_q[W-1:0], dvd_q[W-1]};
   assign pr_next_s   = borrow_s ? pr_shift_s : diff_s;
   assign quo_next_s  = {quo_q[W-2:0], ~borrow_s};
   assign last_iter_s = (cnt_q == CW'(W - 1));

   subnb #(
      .N (W + 1)
   ) u_subnb (
      .a      (pr_shift_s),
      .b      ({1'b0, dvs_q}),
      .Diff   (diff_s),
      .Borrow (borrow_s)
   );

   // Next-state logic for the FSM, datapath registers and result outputs.
   always_comb begin
      state_d    = state_q;
      dvd_d      = dvd_q;
      dvs_d      = dvs_q;
      pr_d       = pr_q;
      quo_d      = quo_q;
      cnt_d      = cnt_q;
      dbz_pend_d = dbz_pend_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      q_d        = q_q;
      r_d        = r_q;
      dbz_d      = dbz_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               dvd_d = A;
               dvs_d = B;
               pr_d  = {(W + 1){1'b0}};
               quo_d = {W{1'b0}};
               cnt_d = {CW{1'b0}};
               if (B != {W{1'b0}}) begin
                  state_d = CALC;
                  busy_d  = 1'b1;
               end else begin
                  state_d    = DONE;
                  dbz_pend_d = 1'b1;
               end
            end else begin
               state_d = IDLE;
            end
         end
         CALC: begin
            pr_d  = pr_next_s;
            quo_d = quo_next_s;
            dvd_d = {dvd_q[W-2:0], 1'b0};
            cnt_d = cnt_q + CW'(1);
            if (last_iter_s) begin
               q_d     = quo_next_s;
               r_d     = pr_next_s[W-1:0];
               dbz_d   = 1'b0;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = DONE;
            end else begin
               state_d = CALC;
            end
         end
         DONE: begin
            if (dbz_pend_q) begin
               // Zero divisor: publish the result one cycle after acceptance.
               q_d        = {W{1'b1}};
               r_d        = dvd_q;
               dbz_d      = 1'b1;
               done_d     = 1'b1;
               dbz_pend_d = 1'b0;
            end else begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d    = IDLE;
            busy_d     = 1'b0;
            dbz_pend_d = 1'b0;
         end
      endcase
   end

   // State and datapath registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         dvd_q      <= {W{1'b0}};
         dvs_q      <= {W{1'b0}};
         pr_q       <= {(W + 1){1'b0}};
         quo_q      <= {W{1'b0}};
         cnt_q      <= {CW{1'b0}};
         dbz_pend_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         q_q        <= {W{1'b0}};
         r_q        <= {W{1'b0}};
         dbz_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         dvd_q      <= dvd_d;
         dvs_q      <= dvs_d;
         pr_q       <= pr_d;
         quo_q      <= quo_d;
         cnt_q      <= cnt_d;
         dbz_pend_q <= dbz_pend_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         q_q        <= q_d;
         r_q        <= r_d;
         dbz_q      <= dbz_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign Q           = q_q;
   assign R           = r_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div4b.sv
// Self-checking bench for div4b: directed cases, handshake corner cases,
// exhaustive sweep and random pairs against an arithmetic reference model.
module tb_div4b;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [3:0] A = 4'd0;
   logic [3:0] B = 4'd0;
   logic       busy;
   logic       done;
   logic [3:0] Q;
   logic [3:0] R;
   logic       div_by_zero;

   int total = 0;
   int bad   = 0;

   div4b #(.W(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .A           (A),
      .B           (B),
      .busy        (busy),
      .done        (done),
      .Q           (Q),
      .R           (R),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference model: plain integer division with the zero-divisor rule.
   function automatic logic [3:0] ref_q(input logic [3:0] a, input logic [3:0] b);
      return (b == 4'd0) ? 4'hF : 4'(int'(a) / int'(b));
   endfunction

   function automatic logic [3:0] ref_r(input logic [3:0] a, input logic [3:0] b);
      return (b == 4'd0) ? a : 4'(int'(a) % int'(b));
   endfunction

   // Issue one operation from IDLE, wait for done, check result and timing.
   // Returns one cycle after done, so the next start lands in IDLE.
   task automatic run_div(input logic [3:0] a, input logic [3:0] b, input string tag);
      int lat;
      bit seen_busy;
      bit got;
      A = a;
      B = b;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      A = 4'($urandom);
      B = 4'($urandom);
      lat = 0;
      got = 1'b0;
      seen_busy = busy;
      for (int k = 0; k < 12; k++) begin
         if (done) begin
            got = 1'b1;
            break;
         end
         @(posedge clk); #1;
         lat++;
         if (busy) seen_busy = 1'b1;
      end
      check({tag, "_done_seen"}, 32'(got), 32'd1);
      if (got) begin
         check({tag, "_latency"}, 32'(lat), (b == 4'd0) ? 32'd1 : 32'd4);
         check({tag, "_busy_ever"}, 32'(seen_busy), (b == 4'd0) ? 32'd0 : 32'd1);
         check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
         check({tag, "_Q"}, 32'(Q), 32'(ref_q(a, b)));
         check({tag, "_R"}, 32'(R), 32'(ref_r(a, b)));
         check({tag, "_dbz"}, 32'(div_by_zero), (b == 4'd0) ? 32'd1 : 32'd0);
         @(posedge clk); #1;
         check({tag, "_done_pulse"}, 32'(done), 32'd0);
         check({tag, "_Q_held"}, 32'(Q), 32'(ref_q(a, b)));
      end
   endtask

   initial begin
      int lat;
      bit got;
      bit extra;
      logic [3:0] ra, rb;

      // Reset state
      #1;
      check("reset_outputs", 32'({busy, done, Q, R, div_by_zero}), 32'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      check("idle_outputs", 32'({busy, done, Q, R, div_by_zero}), 32'd0);

      // Basic and boundary divisions
      run_div(4'd13, 4'd4,  "d13_4");
      run_div(4'd15, 4'd1,  "d15_1");
      run_div(4'd3,  4'd7,  "d3_7");
      run_div(4'd15, 4'd15, "d15_15");
      run_div(4'd9,  4'd0,  "d9_0");
      run_div(4'd6,  4'd3,  "d6_3");

      // Starts during CALC and DONE are ignored
      A = 4'd14; B = 4'd5; start = 1'b1;
      @(posedge clk); #1;                   // t0 accepted
      start = 1'b0;
      @(posedge clk); #1;                   // t1
      A = 4'd1; B = 4'd1; start = 1'b1;     // sampled at t2
      @(posedge clk); #1;
      start = 1'b0;
      lat = 2;
      got = 1'b0;
      for (int k = 0; k < 10; k++) begin
         if (done) begin
            got = 1'b1;
            break;
         end
         @(posedge clk); #1;
         lat++;
      end
      check("ign_done_seen", 32'(got), 32'd1);
      check("ign_latency", 32'(lat), 32'd4);
      check("ign_Q", 32'(Q), 32'd2);
      check("ign_R", 32'(R), 32'd4);
      start = 1'b1;                          // sampled in the DONE cycle
      @(posedge clk); #1;
      start = 1'b0;
      extra = 1'b0;
      for (int k = 0; k < 8; k++) begin
         if (done || busy) extra = 1'b1;
         @(posedge clk); #1;
      end
      check("ign_no_second_op", 32'(extra), 32'd0);
      check("ign_Q_kept", 32'(Q), 32'd2);

      // Reset in the middle of an operation
      A = 4'd11; B = 4'd2; start = 1'b1;
      @(posedge clk); #1;                   // t0
      start = 1'b0;
      @(posedge clk); #1;                   // t1
      @(posedge clk); #1;                   // t2
      rst_n = 1'b0;
      #1;
      check("midrst_outputs", 32'({busy, done, Q, R, div_by_zero}), 32'd0);
      @(posedge clk); @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      extra = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         if (done || busy) extra = 1'b1;
      end
      check("midrst_no_done", 32'(extra), 32'd0);
      run_div(4'd11, 4'd2, "d11_2");

      // Exhaustive sweep at minimum spacing
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            run_div(4'(a), 4'(b), $sformatf("sweep_%0d_%0d", a, b));
         end
      end

      // Random pairs
      for (int n = 0; n < 40; n++) begin
         ra = 4'($urandom);
         rb = 4'($urandom_range(0, 15));
         run_div(ra, rb, $sformatf("rand_%0d_%0d", ra, rb));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
